// File: rtl/sbox_share_compress.sv
// Masked PRINCE S-box share compression: a glitch-barrier register for all domain
// products, then an XOR fold of the selected s/t terms into two output shares.
module sbox_share_compress #(
    parameter int unsigned SPLIT_BIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sel,
    input  logic        in_last,
    input  logic [63:0] dom_s,
    input  logic [63:0] dom_t,
    output logic [3:0]  out_share0,
    output logic [3:0]  out_share1,
    output logic        out_valid,
    output logic        out_last
);

    logic        valid1_q, valid1_d;
    logic        sel_q, sel_d;
    logic        last1_q, last1_d;
    logic [63:0] s_q, s_d;
    logic [63:0] t_q, t_d;

    logic [3:0]  share0_q, share0_d;
    logic [3:0]  share1_q, share1_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;

    logic [63:0] term;

    // Stage 1 is a pure clock-enabled capture so no glitchy logic precedes the barrier.
    always_comb begin
        valid1_d = in_valid;
        sel_d    = sel_q;
        last1_d  = last1_q;
        s_d      = s_q;
        t_d      = t_q;
        if (in_valid) begin
            sel_d   = in_sel;
            last1_d = in_last;
            s_d     = dom_s;
            t_d     = dom_t;
        end
    end

    always_comb begin
        term        = sel_q ? t_q : s_q;
        out_valid_d = valid1_q;
        share0_d    = share0_q;
        share1_d    = share1_q;
        out_last_d  = out_last_q;
        if (valid1_q) begin
            share0_d   = '0;
            share1_d   = '0;
            out_last_d = last1_q;
            for (int unsigned d = 0; d < 16; d++) begin
                if (d[SPLIT_BIT])
                    share1_d = share1_d ^ term[4*d +: 4];
                else
                    share0_d = share0_d ^ term[4*d +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q    <= 1'b0;
            sel_q       <= 1'b0;
            last1_q     <= 1'b0;
            s_q         <= '0;
            t_q         <= '0;
            share0_q    <= '0;
            share1_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            valid1_q    <= valid1_d;
            sel_q       <= sel_d;
            last1_q     <= last1_d;
            s_q         <= s_d;
            t_q         <= t_d;
            share0_q    <= share0_d;
            share1_q    <= share1_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_share0 = share0_q;
    assign out_share1 = share1_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;

endmodule

// File: doc/sbox_share_compress.md
# sbox_share_compress

Registered compression stage placed directly after the 16 first-order domain-product blocks of the masked PRINCE S-box layer. It captures every cross-domain product term in a glitch-barrier register and XOR-compresses the terms into two 4-bit output shares. It selects either the forward (s) or inverse (t) S-box terms and delivers them with a fixed 2-cycle latency under valid tagging.

## Interface
- SPLIT_BIT, 3: index bit of the domain number that assigns a domain to output share 1 (bit = 1) or share 0 (bit = 0); legal values 0..3.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  domain terms and in_sel valid this cycle.
- in_sel  input  1  0 = compress s terms, 1 = compress t terms.
- in_last  input  1  tag marking the last S-box layer of a run; travels with the data.
- dom_s  input  64  s terms: dom_s[4*d+j] = s_j of domain d, d = 0..15; bit i of d is 1 when input bit i is taken from share 1 (y).
- dom_t  input  64  t terms, same packing as dom_s.
- out_share0  output  4  compressed share 0.
- out_share1  output  4  compressed share 1.
- out_valid  output  1  out_share0/out_share1 valid.
- out_last  output  1  in_last delayed with the data.

## Operation
- Stage 1 (glitch barrier): on in_valid = 1, register in_sel, in_last and all 128 bits of dom_s/dom_t unmodified. No logic sits between the input ports and these flops. Set valid1 = 1.
- When in_valid = 0, stage-1 data registers hold their previous value (clock-enabled, no toggling) and valid1 = 0.
- Stage 2 (compression): when valid1 = 1, select the registered s or t vector by the registered sel.
  - share0 = XOR over all d with d[SPLIT_BIT] = 0 of term[4d+3:4d].
  - share1 = XOR over all d with d[SPLIT_BIT] = 1 of term[4d+3:4d].
  - Each share XORs exactly 8 domains.
  - Register the results into out_share0/out_share1 together with out_last, and set out_valid = 1.
- When valid1 = 0, output data registers hold and out_valid = 0.
- s and t terms are never mixed inside one share. Unselected terms are registered but do not reach the output.
- The block has no backpressure. Throughput is one item per cycle, and the consumer must accept every out_valid pulse.
- Reset values:
  - valid1, out_valid, out_last: 0.
  - out_share0, out_share1: 4'h0.
  - All stage-1 registers: 0.

## Timing
- Latency: data accepted at edge k appears on the outputs after edge k+1 (2 register stages). out_valid rises exactly 2 edges after in_valid is sampled high.
- Back-to-back in_valid produces back-to-back out_valid with no bubbles. Gaps on the input are reproduced unchanged on the output.
- in_sel and in_last are sampled on the same edge as the data. Changing in_sel every cycle is legal.
- Asserting rst mid-operation clears both valid stages immediately (asynchronously). No out_valid pulse for in-flight items appears after rst is released. The first item accepted after release has normal 2-cycle latency.
- in_valid sampled while rst is high is ignored.
- out_last is valid only when qualified by out_valid.

## Test plan
- Reset, then in_valid = 1 with all terms 0 and in_sel = 0 -> two cycles later out_valid = 1, out_share0 = out_share1 = 4'h0, out_last = 0.
- Single term dom_s[4*5+2] = 1 (d = 5, bit3 = 0), in_sel = 0, SPLIT_BIT = 3 -> out_share0 = 4'b0100, out_share1 = 4'b0000. Repeat with dom_s[4*12+0] = 1 -> share0 = 0, share1 = 4'b0001.
- dom_s = all ones, dom_t = 0, in_sel = 1 -> both shares 4'h0. Then in_sel = 0 -> both shares 4'h0 (even count of 8 per share). Then set only the d = 0 nibble of dom_t to 4'hF with in_sel = 1 -> share0 = 4'hF, share1 = 4'h0.
- Stream 20 consecutive random items with alternating in_sel and in_last on item 20 -> 20 consecutive out_valid cycles starting 2 cycles after the first input. Every share pair matches the XOR reference model. out_last is high only on output 20.
- Two valid items followed by rst asserted between edges for 1 cycle -> out_valid drops to 0 immediately and stays 0 until a new item is accepted. Outputs read 4'h0 during reset.
- Pattern in_valid = 1, 0, 0, 1 -> out_valid = 1, 0, 0, 1 shifted by 2 cycles. During the gap out_share0/out_share1 hold their last value and stage-1 registers show no toggles.
